// File: rtl/csel_pkg.sv
// Shared constants and result types for the carry/borrow-select datapath blocks.
package csel_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned NBLK  = WIDTH / BLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;
  } sub_res_t;

  // Two's-complement overflow of a - b: operand signs differ and the result sign left the minuend's.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/csel_sub_block.sv
// One borrow-select block: differences and borrows for both possible borrow-in values.
module csel_sub_block
  import csel_pkg::*;
#(
  parameter int unsigned BW = BLOCK
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [BW-1:0] d0,
  output logic          b0,
  output logic [BW-1:0] d1,
  output logic          b1
);

  // The extra top bit of a (BW+1)-bit difference is the borrow out.
  assign {b0, d0} = {1'b0, a} - {1'b0, b};
  assign {b1, d1} = {1'b0, a} - {1'b0, b} - {{BW{1'b0}}, 1'b1};

endmodule

// File: rtl/carry_select_subtractor_pipe.sv
// Two-stage borrow-select subtractor with valid/ready handshake on both sides.
module carry_select_subtractor_pipe
  import csel_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] blk_d0_s, blk_d1_s;
  logic [NBLK-1:0]  blk_b0_s, blk_b1_s;

  logic [WIDTH-1:0] s1_d0_q, s1_d1_q;
  logic [NBLK-1:0]  s1_b0_q, s1_b1_q;
  logic             s1_bin_q, s1_amsb_q, s1_bmsb_q, s1_valid_q;

  logic             out_valid_q;
  sub_res_t         res_q, res_d;
  logic             s1_adv_s, s2_adv_s;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    csel_sub_block #(.BW(BLOCK)) u_blk (
      .a  (a[k*BLOCK +: BLOCK]),
      .b  (b[k*BLOCK +: BLOCK]),
      .d0 (blk_d0_s[k*BLOCK +: BLOCK]),
      .b0 (blk_b0_s[k]),
      .d1 (blk_d1_s[k*BLOCK +: BLOCK]),
      .b1 (blk_b1_s[k])
    );
  end

  // Stall chain depends only on registered valids and the consumer, never on in_valid.
  assign s2_adv_s = !out_valid_q || out_ready;
  assign s1_adv_s = !s1_valid_q || s2_adv_s;
  assign in_ready = s1_adv_s;

  // Stage 1: capture both candidate results of every block plus sign bits and borrow-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_d0_q    <= {WIDTH{1'b0}};
      s1_d1_q    <= {WIDTH{1'b0}};
      s1_b0_q    <= {NBLK{1'b0}};
      s1_b1_q    <= {NBLK{1'b0}};
      s1_bin_q   <= 1'b0;
      s1_amsb_q  <= 1'b0;
      s1_bmsb_q  <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_q <= in_valid;
      s1_d0_q    <= blk_d0_s;
      s1_d1_q    <= blk_d1_s;
      s1_b0_q    <= blk_b0_s;
      s1_b1_q    <= blk_b1_s;
      s1_bin_q   <= bin;
      s1_amsb_q  <= a[WIDTH-1];
      s1_bmsb_q  <= b[WIDTH-1];
    end else begin
      s1_valid_q <= s1_valid_q;
    end
  end

  // Select chain: each block's resolved borrow picks the next block's precomputed result.
  always_comb begin : p_select
    logic br_v;
    br_v       = s1_bin_q;
    res_d.diff = {WIDTH{1'b0}};
    for (int unsigned k = 0; k < NBLK; k++) begin
      res_d.diff[k*BLOCK +: BLOCK] = br_v ? s1_d1_q[k*BLOCK +: BLOCK] : s1_d0_q[k*BLOCK +: BLOCK];
      br_v                         = br_v ? s1_b1_q[k] : s1_b0_q[k];
    end
    res_d.bout = br_v;
    res_d.ovf  = sub_ovf(s1_amsb_q, s1_bmsb_q, res_d.diff[WIDTH-1]);
    res_d.zero = (res_d.diff == {WIDTH{1'b0}});
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= {$bits(sub_res_t){1'b0}};
    end else if (s2_adv_s) begin
      out_valid_q <= s1_valid_q;
      res_q       <= res_d;
    end else begin
      out_valid_q <= out_valid_q;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = res_q.diff;
  assign bout      = res_q.bout;
  assign ovf       = res_q.ovf;
  assign zero      = res_q.zero;

endmodule

// File: tb/tb_carry_select_subtractor_pipe.sv
// Self-checking bench: directed corner cases, backpressure, mid-flight reset and random traffic vs. an arithmetic model.
module tb_carry_select_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, diff;
  logic        bin, bout, ovf, zero;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic [18:0] exp_q[$];
  logic [18:0] hold_val;
  logic        hold_valid = 1'b0;

  carry_select_subtractor_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {diff, bout, ovf, zero}.
  function automatic logic [18:0] ref_model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int          full  = int'(x) - int'(y) - int'(bi);
    int          sfull = int'($signed(x)) - int'($signed(y)) - int'(bi);
    logic [15:0] d     = full[15:0];
    return {d, (full < 0), (sfull < -32768 || sfull > 32767), (d == 16'h0000)};
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic v, input logic [15:0] xa, input logic [15:0] xb,
                       input logic xbin, input logic ordy, output logic acc);
    logic [18:0] cur;
    in_valid  = v;
    a         = xa;
    b         = xb;
    bin       = xbin;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    cur = {diff, bout, ovf, zero};
    if (out_valid && out_ready) begin
      hold_valid = 1'b0;
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'd1, 32'd0);
      end else begin
        check_eq("result", {13'd0, cur}, {13'd0, exp_q.pop_front()});
      end
      n_out++;
    end else if (out_valid) begin
      if (hold_valid) check_eq("hold_stable", {13'd0, cur}, {13'd0, hold_val});
      hold_val   = cur;
      hold_valid = 1'b1;
    end else begin
      hold_valid = 1'b0;
    end
    if (acc) exp_q.push_back(ref_model(xa, xb, xbin));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    check_eq("drain_empty", exp_q.size(), 32'd0);
  endtask

  logic [15:0] dir_a [7] = '{16'h0000, 16'h1234, 16'h8000, 16'h7FFF, 16'h1000, 16'h0000, 16'hFFFF};
  logic [15:0] dir_b [7] = '{16'h0001, 16'h1234, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
  logic        dir_c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] bp_a  [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};

  initial begin
    logic acc;
    int   idx, base_out;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0; b = 16'h0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 32'd0);
    check_eq("rst_outputs", {diff, bout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rdy_after_rst", in_ready, 32'd1);

    // 2-cycle latency for a single transaction
    cycle(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, acc);
    check_eq("first_accept", acc, 32'd1);
    check_eq("lat_cycle1", out_valid, 32'd0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    check_eq("lat_cycle2", out_valid, 32'd1);
    check_eq("first_diff", diff, 32'h0002);
    drain(8);

    // Directed corners streamed back to back
    for (int i = 0; i < 7; i++) cycle(1'b1, dir_a[i], dir_b[i], dir_c[i], 1'b1, acc);
    drain(8);

    // Backpressure: only two accepted while the consumer stalls
    idx = 0;
    base_out = n_out;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bp_a[idx], 16'h0001, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("bp_accepts", idx, 32'd2);
    check_eq("bp_in_ready", in_ready, 32'd0);
    for (int i = 0; i < 20 && (idx < 4 || exp_q.size() > 0); i++) begin
      cycle(idx < 4, bp_a[idx % 4], 16'h0001, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    check_eq("bp_count", n_out - base_out, 32'd4);

    // Reset with two in flight
    cycle(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'h5555, 16'h1111, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 32'd0);
    check_eq("midrst_outputs", {diff, bout, ovf, zero}, 32'd0);
    exp_q.delete();
    hold_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rdy_after_midrst", in_ready, 32'd1);
    cycle(1'b1, 16'h0100, 16'h0001, 1'b1, 1'b1, acc);
    check_eq("post_rst_lat1", out_valid, 32'd0);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    check_eq("post_rst_lat2", out_valid, 32'd1);
    drain(8);

    // Random traffic with random consumer stalls
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 9) == 0) ra = 16'h8000;
      cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 9) < 7, acc);
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
